sd_cmd_tx: RTL and testbench

Serialises one SD-bus command frame onto the CMD line: start bit, transmission bit, 6-bit command index, 32-bit argument, serially computed CRC7 and end bit, 48 bits in total. The block runs entirely on the system clock and advances one bit per SD-clock period, using a one-cycle strobe derived from the SD clock divider. It sits between the SD host controller FSM, which issues commands, and the CMD pad tri-state buffer.

---
 rtl/sd_cmd_tx.sv | 168 ++++++++++++++++
 tb/tb_sd_cmd_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_tx
// Purpose  : Serialises one 48-bit SD-bus command frame onto the CMD line:
//            start bit, transmission bit, 6-bit index, 32-bit argument,
//            serially computed CRC7 and end bit. One bit is driven per
//            istrobe, which is a one-iclk-cycle enable derived from the SD
//            clock divider. After the end bit the line is released for NCC
//            strobe periods before completion is signalled.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NCC      released-line strobe periods after the end bit (1..255)
// Ports
//   iclk     in   1  system clock, rising edge
//   irst_n   in   1  asynchronous active-low reset
//   istrobe  in   1  SD-clock bit enable, one iclk cycle per SD-clock period
//   istart   in   1  command request, accepted while idle
//   iindex   in   6  command index, latched on acceptance
//   iarg     in  32  command argument, latched on acceptance
//   ocmd     out  1  CMD line data (registered, idles high)
//   ocmd_oe  out  1  CMD pad output enable (registered, 1 = drive)
//   obusy    out  1  high from the cycle after acceptance until completion
//   odone    out  1  one-cycle completion pulse
// ============================================================================
module sd_cmd_tx #(
  parameter int NCC = 8
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        istrobe,
  input  logic        istart,
  input  logic [5:0]  iindex,
  input  logic [31:0] iarg,
  output logic        ocmd,
  output logic        ocmd_oe,
  output logic        obusy,
  output logic        odone
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] IDLE = 2'd0;  // waiting for istart
  localparam logic [1:0] WAIT = 2'd1;  // accepted, waiting for the first strobe
  localparam logic [1:0] SEND = 2'd2;  // driving bits 47..0
  localparam logic [1:0] GAP  = 2'd3;  // line released, counting NCC strobes

  localparam logic [5:0] FIRST_BIT   = 6'd47;
  // bit_cnt holds the index of the bit currently on the line; the next bit
  // is a header bit while bit_cnt is above this value.
  localparam logic [5:0] LAST_HDR    = 6'd8;
  localparam logic [5:0] LAST_CRC    = 6'd1;
  localparam logic [7:0] GAP_LAST    = 8'(NCC - 1);
  localparam logic [6:0] CRC7_POLY   = 7'h09;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  state;
  logic [39:0] hdr;       // header shift register, MSB is the next header bit
  logic [6:0]  crc;       // CRC7 accumulator, then CRC output shift register
  logic [5:0]  bit_cnt;   // index of the bit currently driven on ocmd
  logic [7:0]  gap_cnt;   // strobes seen so far in GAP

  // CRC7 (x^7 + x^3 + 1) single-bit update
  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

  // Header-bit step shared by WAIT (start bit) and SEND (remaining header)
  logic [6:0]  crc_fold;
  logic [39:0] hdr_shift;

  always_comb begin
    crc_fold  = crc7_next(crc, hdr[39]);
    hdr_shift = {hdr[38:0], 1'b0};
  end

  // --------------------------------------------------------------------------
  // Main sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state   <= IDLE;
      hdr     <= '0;
      crc     <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      ocmd    <= 1'b1;
      ocmd_oe <= 1'b0;
      obusy   <= 1'b0;
      odone   <= 1'b0;
    end else begin
      // odone is a single-cycle pulse
      odone <= 1'b0;

      case (state)
        IDLE: begin
          // A strobe in the acceptance cycle is deliberately ignored so the
          // start bit always gets a full SD-clock period.
          if (istart) begin
            hdr   <= {1'b0, 1'b1, iindex, iarg};
            crc   <= '0;
            obusy <= 1'b1;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (istrobe) begin
            ocmd    <= hdr[39];
            ocmd_oe <= 1'b1;
            crc     <= crc_fold;
            hdr     <= hdr_shift;
            bit_cnt <= FIRST_BIT;
            state   <= SEND;
          end
        end

        SEND: begin
          if (istrobe) begin
            if (bit_cnt == 6'd0) begin
              // End bit has had its full period: release the line.
              ocmd    <= 1'b1;
              ocmd_oe <= 1'b0;
              gap_cnt <= '0;
              state   <= GAP;
            end else if (bit_cnt > LAST_HDR) begin
              // Next bit is still header: drive it and fold it into the CRC.
              ocmd    <= hdr[39];
              crc     <= crc_fold;
              hdr     <= hdr_shift;
              bit_cnt <= bit_cnt - 6'd1;
            end else if (bit_cnt > LAST_CRC) begin
              // CRC is complete; shift it out MSB first.
              ocmd    <= crc[6];
              crc     <= {crc[5:0], 1'b0};
              bit_cnt <= bit_cnt - 6'd1;
            end else begin
              // End bit
              ocmd    <= 1'b1;
              bit_cnt <= 6'd0;
            end
          end
        end

        GAP: begin
          if (istrobe) begin
            if (gap_cnt == GAP_LAST) begin
              odone <= 1'b1;
              obusy <= 1'b0;
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_tx
// Purpose  : Self-checking bench for sd_cmd_tx. Stimulus pushes the expected
//            48-bit frame into a queue; an independent monitor reassembles
//            each frame from ocmd/ocmd_oe at strobe edges and compares it,
//            along with release timing, odone latency and line stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_tx;

  localparam int NCC = 8;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic        gen_strb = 1'b0;
  logic        man_strb = 1'b0;
  logic        istrobe;
  logic        istart = 1'b0;
  logic [5:0]  iindex = '0;
  logic [31:0] iarg = '0;
  logic        ocmd, ocmd_oe, obusy, odone;

  assign istrobe = gen_strb | man_strb;

  sd_cmd_tx #(.NCC(NCC)) dut (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .istrobe (istrobe),
    .istart  (istart),
    .iindex  (iindex),
    .iarg    (iarg),
    .ocmd    (ocmd),
    .ocmd_oe (ocmd_oe),
    .obusy   (obusy),
    .odone   (odone)
  );

  initial forever #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- strobes
  int period    = 4;
  bit irregular = 1'b0;
  bit strobe_en = 1'b0;
  int scnt      = 0;

  initial forever begin
    @(negedge iclk);
    if (strobe_en) begin
      if (scnt == 0) begin
        gen_strb = 1'b1;
        scnt = irregular ? int'($urandom_range(9, 0)) : period - 1;
      end else begin
        gen_strb = 1'b0;
        scnt--;
      end
    end else begin
      gen_strb = 1'b0;
      scnt = 0;
    end
  end

  // ---------------------------------------------------------------- monitor
  bit          in_frame = 1'b0;
  bit          frame_done = 1'b0;
  int          nbits = 0;
  int          scount = 0;
  logic [47:0] shreg = '0;
  logic        prev_oe = 1'b0, prev_cmd = 1'b1, prev_done = 1'b0;
  bit          sstb;
  logic [47:0] exp_frame;

  always @(posedge iclk) begin
    sstb = istrobe;
    #1;
    if (!irst_n) begin
      in_frame   = 1'b0;
      frame_done = 1'b0;
    end else begin
      if (!sstb && (ocmd_oe !== prev_oe || ocmd !== prev_cmd)) begin
        checks++;
        errors++;
        $display("FAIL line_change_no_strobe: got oe=%0b cmd=%0b expected oe=%0b cmd=%0b",
                 ocmd_oe, ocmd, prev_oe, prev_cmd);
      end
      if (sstb && in_frame) scount++;
      if (sstb && ocmd_oe) begin
        if (!in_frame) begin
          in_frame   = 1'b1;
          frame_done = 1'b0;
          nbits      = 0;
          scount     = 1;
        end else if (frame_done) begin
          checks++;
          errors++;
          $display("FAIL oe_in_gap: got oe=1 expected oe=0 at %0t", $time);
        end
        shreg = {shreg[46:0], ocmd};
        nbits++;
      end
      if (sstb && in_frame && !frame_done && !ocmd_oe) begin
        frame_done = 1'b1;
        check("frame_bits", 64'(nbits), 64'd48);
        check("release_cmd_high", 64'(ocmd), 64'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got 0x%0h expected none", shreg);
        end else begin
          exp_frame = exp_q.pop_front();
          check("frame", 64'(shreg), 64'(exp_frame));
        end
      end
      if (odone) begin
        check("done_after_frame", 64'(in_frame && frame_done), 64'd1);
        check("done_latency", 64'(scount), 64'(49 + NCC));
        check("busy_clear_on_done", 64'(obusy), 64'd0);
        in_frame   = 1'b0;
        frame_done = 1'b0;
      end
      if (odone && prev_done) begin
        checks++;
        errors++;
        $display("FAIL done_pulse_width: got 2+ cycles expected 1");
      end
    end
    prev_oe   = ocmd_oe;
    prev_cmd  = ocmd;
    prev_done = odone;
  end

  // ---------------------------------------------------------------- tasks
  // Called at a negedge with the DUT idle.
  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp);
    istart = 1'b1;
    iindex = idx;
    iarg   = arg;
    exp_q.push_back(exp);
    @(negedge iclk);
    istart = 1'b0;
    iindex = 6'($urandom);
    iarg   = $urandom;
    check("busy_after_accept", 64'(obusy), 64'd1);
    check("oe_after_accept", 64'(ocmd_oe), 64'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((obusy || exp_q.size() != 0) && n < 5000) begin
      @(negedge iclk);
      n++;
    end
    check("idle_timeout", 64'(n >= 5000), 64'd0);
    repeat (3) @(negedge iclk);
  endtask

  task automatic wait_oe();
    int n = 0;
    while (!ocmd_oe && n < 500) begin
      @(negedge iclk);
      n++;
    end
    check("oe_timeout", 64'(n >= 500), 64'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    repeat (3) @(negedge iclk);
    check("rst_cmd", 64'(ocmd), 64'd1);
    check("rst_oe", 64'(ocmd_oe), 64'd0);
    check("rst_busy", 64'(obusy), 64'd0);
    check("rst_done", 64'(odone), 64'd0);
    irst_n = 1'b1;
    strobe_en = 1'b1;
    repeat (2) @(negedge iclk);

    // Regular strobes, every 4 cycles
    issue(6'd0,  32'h0000_0000, 48'h4000_0000_0095); wait_idle();
    issue(6'd8,  32'h0000_01AA, 48'h4800_0001_AA87); wait_idle();
    issue(6'd17, 32'h0000_0000, 48'h5100_0000_0055); wait_idle();

    // istart coincident with a strobe, then an ignored istart during SEND
    strobe_en = 1'b0;
    @(negedge iclk);
    istart = 1'b1; iindex = 6'd8; iarg = 32'h0000_01AA; man_strb = 1'b1;
    exp_q.push_back(48'h4800_0001_AA87);
    @(negedge iclk);
    istart = 1'b0; man_strb = 1'b0; iindex = '0; iarg = '0;
    check("coinc_busy", 64'(obusy), 64'd1);
    check("coinc_oe", 64'(ocmd_oe), 64'd0);
    repeat (3) @(negedge iclk);
    check("coinc_oe_hold", 64'(ocmd_oe), 64'd0);
    strobe_en = 1'b1;
    wait_oe();
    repeat (40) @(negedge iclk);
    istart = 1'b1; iindex = 6'h3F; iarg = 32'hFFFF_FFFF;
    @(negedge iclk);
    istart = 1'b0;
    check("busy_ignore_start", 64'(obusy), 64'd1);
    wait_idle();

    // Asynchronous reset in the middle of SEND
    issue(6'd55, 32'hDEAD_BEEF, 48'h0);
    wait_oe();
    repeat (30) @(negedge iclk);
    #2 irst_n = 1'b0;
    #1;
    check("abort_cmd", 64'(ocmd), 64'd1);
    check("abort_oe", 64'(ocmd_oe), 64'd0);
    check("abort_busy", 64'(obusy), 64'd0);
    check("abort_done", 64'(odone), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge iclk);
    irst_n = 1'b1;
    repeat (2) @(negedge iclk);
    issue(6'd17, 32'h0000_0000, 48'h5100_0000_0055); wait_idle();

    // Back-to-back: second istart in the odone cycle
    issue(6'd8, 32'h0000_01AA, 48'h4800_0001_AA87);
    begin
      int n = 0;
      while (odone !== 1'b1 && n < 2000) begin
        @(negedge iclk);
        n++;
      end
    end
    check("b2b_done_seen", 64'(odone), 64'd1);
    check("b2b_idle_in_done", 64'(obusy), 64'd0);
    issue(6'd0, 32'h0000_0000, 48'h4000_0000_0095);
    wait_idle();

    // Irregular strobe spacing, 1..10 cycles
    irregular = 1'b1;
    @(negedge iclk);
    issue(6'd8,  32'h0000_01AA, 48'h4800_0001_AA87); wait_idle();
    issue(6'd0,  32'h0000_0000, 48'h4000_0000_0095); wait_idle();
    issue(6'd17, 32'h0000_0000, 48'h5100_0000_0055); wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
